// File: rtl/serial595_scheduler.sv
// Shared front end for the serial 595 chain: byte-write arbitration into a shadow image, and frame sequencing.
// Optional SERIAL595_REFRESH_EN periodically rewrites an unchanged image.
module serial595_scheduler #(
    parameter int NUM_OF_595_LINE = 16,
    parameter int LINE_BYTES      = 1,
    parameter int NUM_REQ         = 4,
    parameter int TIMEOUT_CYCLES  = 1023,
    parameter int REFRESH_CYCLES  = 50000,
    localparam int IMG_W          = NUM_OF_595_LINE * LINE_BYTES * 8,
    localparam int NBYTES         = IMG_W / 8,
    localparam int AW             = 8
) (
    input  logic                  base_clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]  req_byte,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  chain_trigger,
    output logic [IMG_W-1:0]      chain_data,
    input  logic                  chain_sto,
    output logic                  busy,
    output logic [15:0]           frame_count,
    output logic                  timeout_err,
    output logic                  bad_addr_err
);

    localparam int PW    = $clog2(NUM_REQ);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRIG      = 2'd1,
        WAIT_CLR  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     grant_idx;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [7:0]        wr_data;
    logic              addr_ok;
    int                scan_idx;
    logic [IMG_W-1:0]  image, image_next;
    logic              dirty;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_expired;
    logic              snapshot, frame_done, tmo_hit;
    logic              refresh_hit;

    // Round-robin search starting at rr_ptr; the first valid requester wins.
    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!wr_en && req_valid[scan_idx]) begin
                wr_en     = 1'b1;
                grant_idx = PW'(scan_idx);
                wr_addr   = req_addr[scan_idx*AW +: AW];
                wr_data   = req_byte[scan_idx*8 +: 8];
            end
        end
        if (wr_en) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign addr_ok = (int'(wr_addr) < NBYTES);

    always_comb begin
        image_next = image;
        if (wr_en && addr_ok) begin
            image_next[int'(wr_addr)*8 +: 8] = wr_data;
        end
    end

    assign tmo_expired = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge base_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        snapshot   = 1'b0;
        frame_done = 1'b0;
        tmo_hit    = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (dirty) begin
                    snapshot   = 1'b1;
                    state_next = TRIG;
                end
            end
            TRIG: begin
                state_next = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (tmo_expired) begin
                    tmo_hit    = 1'b1;
                    state_next = IDLE;
                end else if (!chain_sto) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (chain_sto) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end else if (tmo_expired) begin
                    tmo_hit    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef SERIAL595_REFRESH_EN
    logic [31:0] refresh_cnt;

    assign refresh_hit = (state == IDLE) && !dirty && (refresh_cnt == 32'(REFRESH_CYCLES - 1));

    always_ff @(posedge base_clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
        end else if (state == TRIG || refresh_hit) begin
            refresh_cnt <= '0;
        end else if (state == IDLE && !dirty) begin
            refresh_cnt <= refresh_cnt + 32'd1;
        end
    end
`else
    assign refresh_hit = 1'b0;
`endif

    // Trigger is a flop so it cannot glitch while the state decodes settle.
    always_ff @(posedge base_clk or negedge rst_n) begin
        if (!rst_n) begin
            image         <= '0;
            chain_data    <= '0;
            chain_trigger <= 1'b0;
            dirty         <= 1'b0;
            rr_ptr        <= '0;
            tmo_cnt       <= '0;
            frame_count   <= '0;
            timeout_err   <= 1'b0;
            bad_addr_err  <= 1'b0;
        end else begin
            image         <= image_next;
            chain_trigger <= snapshot;
            if (snapshot) begin
                chain_data <= image_next;
            end
            if (wr_en) begin
                rr_ptr <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (wr_en && !addr_ok) begin
                bad_addr_err <= 1'b1;
            end
            if (snapshot) begin
                dirty <= 1'b0;
            end
            if (tmo_hit || refresh_hit || (wr_en && addr_ok)) begin
                dirty <= 1'b1;
            end
            if (state == TRIG) begin
                tmo_cnt <= '0;
            end else if (state == WAIT_CLR || state == WAIT_DONE) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_hit) begin
                timeout_err <= 1'b1;
            end
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_serial595_scheduler.sv
// Scoreboarded bench for serial595_scheduler: expected frame images are queued as writes are driven
// and compared against chain_data at every chain_trigger pulse.
module tb_serial595_scheduler;

    localparam int NUM_REQ = 4;
    localparam int AW      = 8;
    localparam int IMG_W   = 128;
    localparam int TIMEOUT = 100;
    localparam int REFRESH = 500;

    logic                  base_clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ*AW-1:0] req_addr = '0;
    logic [NUM_REQ*8-1:0]  req_byte = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  chain_trigger;
    logic [IMG_W-1:0]      chain_data;
    logic                  chain_sto;
    logic                  busy;
    logic [15:0]           frame_count;
    logic                  timeout_err;
    logic                  bad_addr_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int trig_count = 0;
    int trig_cycle = 0;
    int busy_cycles = 0;
    int sto_delay = 40;
    logic sto_hang = 1'b0;
    logic [IMG_W-1:0] model_img = '0;
    logic [IMG_W-1:0] frame_a;
    logic [IMG_W-1:0] exp_q[$];

    serial595_scheduler #(
        .NUM_OF_595_LINE(16),
        .LINE_BYTES(1),
        .NUM_REQ(NUM_REQ),
        .TIMEOUT_CYCLES(TIMEOUT),
        .REFRESH_CYCLES(REFRESH)
    ) dut (
        .base_clk(base_clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_byte(req_byte),
        .req_ready(req_ready),
        .chain_trigger(chain_trigger),
        .chain_data(chain_data),
        .chain_sto(chain_sto),
        .busy(busy),
        .frame_count(frame_count),
        .timeout_err(timeout_err),
        .bad_addr_err(bad_addr_err)
    );

    always #5 base_clk = ~base_clk;
    always @(posedge base_clk) cyc++;

    task automatic checkOutput(input string tag, input logic [IMG_W-1:0] actual, input logic [IMG_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Chain driver model: sto drops the cycle after trigger and returns sto_delay cycles after trigger.
    initial begin : chain_model
        chain_sto = 1'b1;
        forever begin
            @(negedge base_clk);
            if (!rst_n) begin
                chain_sto = 1'b1;
            end else if (chain_trigger) begin
                @(posedge base_clk);
                #1 chain_sto = 1'b0;
                if (!sto_hang) begin
                    repeat (sto_delay - 1) @(posedge base_clk);
                    #1 chain_sto = 1'b1;
                end
            end
        end
    end

    always @(negedge base_clk) begin
        if (rst_n && chain_trigger) begin
            trig_count++;
            trig_cycle = cyc;
            checkOutput("busy_at_trigger", busy, 1);
            if (exp_q.size() > 0) begin
                checkOutput("frame_data", chain_data, exp_q.pop_front());
            end else begin
`ifdef SERIAL595_REFRESH_EN
                checkOutput("refresh_data", chain_data, model_img);
`else
                checkOutput("unexpected_trigger", 1, 0);
`endif
            end
        end
        if (busy) busy_cycles++;
    end

    initial begin : watchdog
        #(60000 * 10);
        $display("[TB] FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge base_clk);
        #1;
    endtask

    task automatic doReset();
        checkOutput("sb_drained", exp_q.size(), 0);
        exp_q.delete();
        req_valid = '0;
        req_addr  = '0;
        req_byte  = '0;
        sto_hang  = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_outputs", {chain_trigger, busy, timeout_err, bad_addr_err, frame_count, req_ready}, 0);
        checkOutput("rst_data", chain_data, 0);
        repeat (3) @(posedge base_clk);
        #1;
        rst_n       = 1'b1;
        model_img   = '0;
        trig_count  = 0;
        busy_cycles = 0;
    endtask

    // One write from a single requester; the grant must be immediate since nobody else is asking.
    task automatic applyStimulus(input int req, input logic [7:0] addr, input logic [7:0] data);
        logic [NUM_REQ-1:0] onehot;
        int a;
        onehot = '0;
        onehot[req] = 1'b1;
        a = int'(addr);
        req_valid[req] = 1'b1;
        req_addr[req*AW +: AW] = addr;
        req_byte[req*8 +: 8] = data;
        @(negedge base_clk);
        checkOutput("ready_onehot", req_ready, onehot);
        @(posedge base_clk);
        #1;
        req_valid[req] = 1'b0;
        if (a < IMG_W / 8) model_img[a*8 +: 8] = data;
    endtask

    task automatic waitFrames(input string tag, input int target, input int budget);
        int n = 0;
        while (frame_count != 16'(target) && n < budget) begin
            @(negedge base_clk);
            n++;
        end
        checkOutput(tag, frame_count, target);
        idle(1);
    endtask

    task automatic waitTrig(input string tag, input int target, input int budget);
        int n = 0;
        while (trig_count < target && n < budget) begin
            @(negedge base_clk);
            n++;
        end
        checkOutput(tag, trig_count, target);
        idle(1);
    endtask

    initial begin : main
        logic [NUM_REQ-1:0] grant_exp [4];
        logic [IMG_W-1:0] frame1;
        int n;
        int rel_cyc;
        grant_exp[0] = 4'b0001;
        grant_exp[1] = 4'b0100;
        grant_exp[2] = 4'b1000;
        grant_exp[3] = 4'b0001;

        doReset();
        rel_cyc = cyc;

`ifdef SERIAL595_REFRESH_EN
        sto_delay = 20;
        waitTrig("refresh_trig", 1, REFRESH + 50);
        checkOutput("refresh_timing", (trig_cycle - rel_cyc >= REFRESH) && (trig_cycle - rel_cyc <= REFRESH + 3), 1);
        waitFrames("refresh_frame", 1, 100);
        applyStimulus(2, 8'd2, 8'h77);
        exp_q.push_back(model_img);
        waitFrames("write_frame", 2, 100);
        waitTrig("refresh_again", 3, REFRESH + 50);
        waitFrames("refresh_frame2", 3, 100);
`else
        // Quiet idle after reset.
        idle(2000);
        checkOutput("idle_triggers", trig_count, 0);
        checkOutput("idle_outputs", {busy, timeout_err, bad_addr_err, frame_count, req_ready}, 0);
        checkOutput("idle_data", chain_data, 0);

        // Single write, sto returns 40 cycles after trigger.
        sto_delay = 40;
        busy_cycles = 0;
        applyStimulus(1, 8'd3, 8'hA5);
        exp_q.push_back(model_img);
        waitFrames("frame1_count", 1, 200);
        checkOutput("busy_length", busy_cycles, 41);
        checkOutput("byte3", chain_data[31:24], 8'hA5);
        checkOutput("other_bits", chain_data & ~(128'hFF << 24), 0);
        idle(50);
        checkOutput("one_trigger", trig_count, 1);

        // Round-robin with requesters 0, 2, 3 all valid from pointer 0.
        doReset();
        sto_delay = 10;
        req_addr[0*AW +: AW] = 8'd0;  req_byte[0*8 +: 8] = 8'h10;
        req_addr[2*AW +: AW] = 8'd2;  req_byte[2*8 +: 8] = 8'h22;
        req_addr[3*AW +: AW] = 8'd3;  req_byte[3*8 +: 8] = 8'h33;
        frame1 = '0;
        frame1[7:0]   = 8'h10;
        frame1[23:16] = 8'h22;
        model_img = frame1;
        model_img[31:24] = 8'h33;
        exp_q.push_back(frame1);
        exp_q.push_back(model_img);
        req_valid = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            @(negedge base_clk);
            checkOutput("rr_grant", req_ready, grant_exp[i]);
            @(posedge base_clk);
            #1;
        end
        req_valid = '0;
        waitFrames("arb_frames", 2, 300);
        idle(30);
        checkOutput("arb_triggers", trig_count, 2);

        // Write landing during WAIT_DONE produces exactly one follow-up frame.
        doReset();
        sto_delay = 40;
        applyStimulus(0, 8'd3, 8'h11);
        frame_a = model_img;
        exp_q.push_back(model_img);
        waitTrig("first_trig", 1, 20);
        idle(10);
        applyStimulus(2, 8'd5, 8'h5A);
        exp_q.push_back(model_img);
        @(negedge base_clk);
        checkOutput("hold_data", chain_data, frame_a);
        checkOutput("still_busy", busy, 1);
        idle(1);
        waitFrames("second_frame", 2, 300);
        idle(100);
        checkOutput("follow_up_count", trig_count, 2);
        checkOutput("byte5", chain_data[47:40], 8'h5A);

        // sto never returns: timeout then a retry of the same image.
        doReset();
        sto_hang = 1'b1;
        applyStimulus(1, 8'd7, 8'h3C);
        exp_q.push_back(model_img);
        exp_q.push_back(model_img);
        waitTrig("tmo_first_trig", 1, 20);
        n = 0;
        while (!timeout_err && n < 300) begin
            @(negedge base_clk);
            n++;
        end
        checkOutput("tmo_flag", timeout_err, 1);
        checkOutput("tmo_latency", cyc - trig_cycle, TIMEOUT + 1);
        checkOutput("tmo_frames", frame_count, 0);
        idle(1);
        waitTrig("tmo_retry", 2, 10);
        checkOutput("tmo_frames_after", frame_count, 0);

        // Out-of-range address: flagged, image untouched, no frame.
        doReset();
        applyStimulus(3, 8'd16, 8'hFF);
        idle(50);
        checkOutput("bad_addr_flag", bad_addr_err, 1);
        checkOutput("bad_addr_trig", trig_count, 0);
        checkOutput("bad_addr_data", chain_data, 0);
        checkOutput("bad_addr_busy", busy, 0);
`endif

        checkOutput("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
